// File: rtl/branch_pkg.sv
// Shared branch-op encodings, BHT counter constants and branch target helper.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BNE  = 3'b001,
    BR_J    = 3'b010,
    BR_JR   = 3'b011,
    BR_BEQ  = 3'b100,
    BR_BLEZ = 3'b101,
    BR_BGTZ = 3'b110,
    BR_JAL  = 3'b111
  } brop_e;

  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_MAX = 2'b11;

  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [15:0] off);
    return pc4 + {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/bht_bimodal.sv
// Bimodal table of 2-bit saturating counters: one combinational read port
// (returns the pre-update value on a same-index collision) and one update port.
module bht_bimodal
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     rd_taken,
  input  logic                     upd_en,
  input  logic [$clog2(DEPTH)-1:0] upd_idx,
  input  logic                     upd_taken
);

  logic [1:0] ctr [DEPTH];

  assign rd_taken = ctr[rd_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ctr[i] <= CTR_WNT;
      end
    end else if (upd_en) begin
      if (upd_taken && ctr[upd_idx] != CTR_MAX) begin
        ctr[upd_idx] <= ctr[upd_idx] + 2'd1;
      end else if (!upd_taken && ctr[upd_idx] != 2'b00) begin
        ctr[upd_idx] <= ctr[upd_idx] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Registered branch resolution with bimodal prediction, redirect/link outputs
// and saturating performance counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      i_f_pc,
  output logic             o_f_pred_taken,
  input  logic             i_r_valid,
  input  logic             i_r_stall,
  input  logic [31:0]      i_r_pc,
  input  logic [2:0]       i_r_brop,
  input  logic [31:0]      i_r_a,
  input  logic [31:0]      i_r_b,
  input  logic [15:0]      i_r_offset,
  input  logic [25:0]      i_r_target,
  input  logic             i_r_pred_taken,
  output logic             o_redirect_valid,
  output logic [31:0]      o_redirect_pc,
  output logic             o_link_valid,
  output logic [31:0]      o_link_pc,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispredict_cnt
);

  localparam int unsigned IDX = $clog2(BHT_DEPTH);

  brop_e       op;
  logic [31:0] pc4;
  logic [31:0] target;
  logic        taken;
  logic        cond;
  logic        accept;
  logic        active;
  logic        mispredict;
  logic        unused_bits;

  assign op          = brop_e'(i_r_brop);
  assign pc4         = i_r_pc + 32'd4;
  assign unused_bits = ^{i_f_pc[31:IDX+2], i_f_pc[1:0]};

  always_comb begin
    taken  = 1'b0;
    cond   = 1'b0;
    target = branch_target(pc4, i_r_offset);
    case (op)
      BR_BNE:  begin cond = 1'b1; taken = (i_r_a != i_r_b); end
      BR_BEQ:  begin cond = 1'b1; taken = (i_r_a == i_r_b); end
      BR_BLEZ: begin cond = 1'b1; taken = ($signed(i_r_a) <= 0); end
      BR_BGTZ: begin cond = 1'b1; taken = ($signed(i_r_a) > 0); end
      BR_J, BR_JAL: begin taken = 1'b1; target = {pc4[31:28], i_r_target, 2'b00}; end
      BR_JR:   begin taken = 1'b1; target = i_r_a; end
      default: ;
    endcase
  end

  // The slot right after a redirect is the wrong path, so it is never accepted.
  assign accept = i_r_valid & ~i_r_stall & ~o_redirect_valid;
  assign active = accept & (op != BR_NONE);
  // Fetch cannot know the JR register value, so JR always redirects.
  assign mispredict = active & ((taken != i_r_pred_taken) | (op == BR_JR));

  bht_bimodal #(.DEPTH(BHT_DEPTH)) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (i_f_pc[IDX+1:2]),
    .rd_taken  (o_f_pred_taken),
    .upd_en    (accept & cond),
    .upd_idx   (i_r_pc[IDX+1:2]),
    .upd_taken (taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
      o_link_valid     <= 1'b0;
      o_link_pc        <= '0;
      o_branch_cnt     <= '0;
      o_mispredict_cnt <= '0;
    end else begin
      o_redirect_valid <= mispredict;
      o_link_valid     <= accept & (op == BR_JAL);
      if (mispredict) begin
        o_redirect_pc <= taken ? target : pc4;
      end
      if (accept && op == BR_JAL) begin
        o_link_pc <= i_r_pc + 32'd8;
      end
      if (active && o_branch_cnt != '1) begin
        o_branch_cnt <= o_branch_cnt + 1'b1;
      end
      if (mispredict && o_mispredict_cnt != '1) begin
        o_mispredict_cnt <= o_mispredict_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit; 4-bit counters expose saturation.
module tb_branch_predict_unit;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   f_pc;
  logic          f_pred;
  logic          r_valid, r_stall, r_pred;
  logic [31:0]   r_pc, r_a, r_b;
  logic [2:0]    r_brop;
  logic [15:0]   r_off;
  logic [25:0]   r_tgt;
  logic          rd_valid, lk_valid;
  logic [31:0]   rd_pc, lk_pc;
  logic [CW-1:0] b_cnt, m_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.BHT_DEPTH(64), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_f_pc           (f_pc),
    .o_f_pred_taken   (f_pred),
    .i_r_valid        (r_valid),
    .i_r_stall        (r_stall),
    .i_r_pc           (r_pc),
    .i_r_brop         (r_brop),
    .i_r_a            (r_a),
    .i_r_b            (r_b),
    .i_r_offset       (r_off),
    .i_r_target       (r_tgt),
    .i_r_pred_taken   (r_pred),
    .o_redirect_valid (rd_valid),
    .o_redirect_pc    (rd_pc),
    .o_link_valid     (lk_valid),
    .o_link_pc        (lk_pc),
    .o_branch_cnt     (b_cnt),
    .o_mispredict_cnt (m_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic req(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] a,
                     input logic [31:0] b, input logic [15:0] off, input logic [25:0] tgt,
                     input logic pred);
    r_valid = 1'b1; r_brop = op; r_pc = pc; r_a = a; r_b = b;
    r_off = off; r_tgt = tgt; r_pred = pred;
  endtask

  task automatic idle();
    r_valid = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_state(input string tag, input logic rv, input logic [31:0] rpc,
                              input int bc, input int mc);
    check({tag, ".rv"}, 32'(rd_valid), 32'(rv));
    if (rv) check({tag, ".rpc"}, rd_pc, rpc);
    check({tag, ".bcnt"}, 32'(b_cnt), 32'(bc));
    check({tag, ".mcnt"}, 32'(m_cnt), 32'(mc));
  endtask

  initial begin
    rst_n = 1'b0; f_pc = 32'h40; r_stall = 1'b0;
    r_valid = 1'b0; r_brop = 3'd0; r_pc = '0; r_a = '0; r_b = '0;
    r_off = '0; r_tgt = '0; r_pred = 1'b0;
    #3;
    check("rst.pred40", 32'(f_pred), 0);
    check("rst.rv", 32'(rd_valid), 0);
    check("rst.rpc", rd_pc, 0);
    check("rst.lv", 32'(lk_valid), 0);
    check("rst.lpc", lk_pc, 0);
    check("rst.bcnt", 32'(b_cnt), 0);
    check("rst.mcnt", 32'(m_cnt), 0);
    tick(); rst_n = 1'b1;

    // BEQ taken, predicted not-taken -> redirect 0x114
    req(3'b100, 32'h100, 5, 5, 16'h0004, 0, 0); tick();
    expect_state("beq", 1, 32'h114, 1, 1);
    idle(); tick();
    check("beq.drop", 32'(rd_valid), 0);
    f_pc = 32'h100; #1;
    check("beq.pred", 32'(f_pred), 1);

    // BNE taken x3 to self (index 0 shared with 0x100), counter saturates
    for (int i = 0; i < 3; i++) begin
      req(3'b001, 32'h200, 1, 2, 16'hFFFF, 0, 1); tick();
      expect_state("bne.t", 0, 0, 2 + i, 1);
    end
    req(3'b001, 32'h200, 3, 3, 16'hFFFF, 0, 1); tick();
    expect_state("bne.nt1", 1, 32'h204, 5, 2);
    f_pc = 32'h200; #1;
    check("bne.pred2", 32'(f_pred), 1);
    idle(); tick();
    req(3'b001, 32'h200, 3, 3, 16'hFFFF, 0, 1); tick();
    expect_state("bne.nt2", 1, 32'h204, 6, 3);
    check("bne.pred1", 32'(f_pred), 0);
    idle(); tick();

    // JR with pred=1 still redirects
    req(3'b011, 32'h300, 32'h8000_0000, 0, 0, 0, 1); tick();
    expect_state("jr", 1, 32'h8000_0000, 7, 4);
    idle(); tick();

    // JAL: redirect + link; a request in the redirect cycle is ignored
    req(3'b111, 32'h0040_0010, 0, 0, 0, 26'h0000123, 0); tick();
    expect_state("jal", 1, 32'h0000_048C, 8, 5);
    check("jal.lv", 32'(lk_valid), 1);
    check("jal.lpc", lk_pc, 32'h0040_0018);
    req(3'b100, 32'h500, 1, 1, 16'h0004, 0, 0); tick();
    expect_state("shadow", 0, 0, 8, 5);
    check("shadow.lv", 32'(lk_valid), 0);
    idle(); tick();

    // Stall for 3 cycles, then release -> single redirect to 0x644
    r_stall = 1'b1;
    req(3'b100, 32'h600, 7, 7, 16'h0010, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state("stall", 0, 0, 8, 5);
    end
    r_stall = 1'b0; tick();
    expect_state("unstall", 1, 32'h644, 9, 6);
    idle(); tick();
    check("unstall.drop", 32'(rd_valid), 0);

    // NONE ignored
    req(3'b000, 32'h680, 0, 0, 0, 0, 1); tick();
    expect_state("none", 0, 0, 9, 6);

    // Signed compares
    req(3'b101, 32'h700, 32'hFFFF_FFFF, 0, 16'h0002, 0, 0); tick();
    expect_state("blez.neg", 1, 32'h70C, 10, 7);
    idle(); tick();
    req(3'b110, 32'h700, 32'h8000_0000, 0, 16'h0002, 0, 0); tick();
    expect_state("bgtz.neg", 0, 0, 11, 7);
    req(3'b110, 32'h700, 1, 0, 16'h0002, 0, 1); tick();
    expect_state("bgtz.pos", 0, 0, 12, 7);
    req(3'b101, 32'h700, 1, 0, 16'h0002, 0, 0); tick();
    expect_state("blez.pos", 0, 0, 13, 7);

    // J: keeps PC region bits; branch counter saturates at 15
    req(3'b010, 32'h1000_0000, 0, 0, 0, 26'h10, 1); tick();
    expect_state("j.ok", 0, 0, 14, 7);
    req(3'b010, 32'h1000_0000, 0, 0, 0, 26'h10, 0); tick();
    expect_state("j.mp", 1, 32'h1000_0040, 15, 8);
    idle(); tick();
    req(3'b010, 32'h1000_0000, 0, 0, 0, 26'h10, 1); tick();
    expect_state("bcnt.sat", 0, 0, 15, 8);

    // Mispredict counter saturation
    for (int i = 0; i < 8; i++) begin
      req(3'b011, 32'h300, 32'h1234, 0, 0, 0, 1); tick();
      idle(); tick();
    end
    check("mcnt.sat", 32'(m_cnt), 15);
    f_pc = 32'h100; #1;
    check("pre_rst.pred100", 32'(f_pred), 1);

    // Same-index read during train, then async reset mid-pulse
    tick();
    f_pc = 32'h804;
    req(3'b100, 32'h804, 9, 9, 16'h0001, 0, 0);
    #1 check("rbw.before", 32'(f_pred), 0);
    @(posedge clk);
    #1 check("rbw.after", 32'(f_pred), 1);
    check("rbw.rv", 32'(rd_valid), 1);
    check("rbw.rpc", rd_pc, 32'h80C);
    idle();
    #1 rst_n = 1'b0;
    #1;
    check("arst.rv", 32'(rd_valid), 0);
    check("arst.rpc", rd_pc, 0);
    check("arst.pred804", 32'(f_pred), 0);
    check("arst.bcnt", 32'(b_cnt), 0);
    check("arst.mcnt", 32'(m_cnt), 0);
    f_pc = 32'h100; #1;
    check("arst.pred100", 32'(f_pred), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
